// File: rtl/barrett_correction.sv
// Purpose : final Barrett correction; r = (x - q*m) mod 2^rw, then up to two
//           conditional subtractions of m, giving r < m (out_err if not).
// Latency : 3 cycles from the accepting edge to out_valid.
// Backpres: one operand set in flight; in_ready only in IDLE; result held
//           in DONE until out_ready.
// Ports   : clk, rst_n (async, active-low)
//           in_valid/in_ready, x_lo[rw], qm_lo[rw], m[width]  -- operand side
//           out_valid/out_ready, r[width], out_err            -- result side
module barrett_correction #(
  parameter int width = 110,
  parameter int rw    = 112
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [rw-1:0]    x_lo,
  input  logic [rw-1:0]    qm_lo,
  input  logic [width-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] r,
  output logic             out_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUB,
    ST_COR1,
    ST_COR2,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [rw-1:0]    x_q, x_d;
  logic [rw-1:0]    qm_q, qm_d;
  logic [width-1:0] m_q, m_d;
  logic [rw-1:0]    t_q, t_d;
  logic [width-1:0] r_q, r_d;
  logic             out_err_q, out_err_d;

  // Shared correction datapath: one rw-bit compare plus subtract on t_q,
  // used by both COR1 and COR2.
  logic [rw-1:0] m_ext;
  logic          t_ge;
  logic [rw-1:0] t_sub;
  logic [rw-1:0] t_cor;
  logic          t2_ge;

  always_comb begin
    m_ext = {{(rw-width){1'b0}}, m_q};
    t_ge  = (t_q >= m_ext);
    t_sub = t_q - m_ext;
    t_cor = t_ge ? t_sub : t_q;
    // Also catches nonzero bits above width, since m_ext < 2^width.
    t2_ge = (t_cor >= m_ext);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    qm_d      = qm_q;
    m_d       = m_q;
    t_d       = t_q;
    r_d       = r_q;
    out_err_d = out_err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = x_lo;
          qm_d    = qm_lo;
          m_d     = m;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        // Borrow out of the top is discarded: arithmetic is mod 2^rw.
        t_d     = x_q - qm_q;
        state_d = ST_COR1;
      end
      ST_COR1: begin
        t_d     = t_cor;
        state_d = ST_COR2;
      end
      ST_COR2: begin
        r_d       = t_cor[width-1:0];
        out_err_d = t2_ge;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      qm_q      <= '0;
      m_q       <= '0;
      t_q       <= '0;
      r_q       <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      qm_q      <= qm_d;
      m_q       <= m_d;
      t_q       <= t_d;
      r_q       <= r_d;
      out_err_q <= out_err_d;
    end
  end

  assign r       = r_q;
  assign out_err = out_err_q;

endmodule

// File: tb/tb_barrett_correction.sv
module tb_barrett_correction;

  localparam int W  = 110;
  localparam int RW = 112;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [RW-1:0] x_lo      = '0;
  logic [RW-1:0] qm_lo     = '0;
  logic [W-1:0]  m         = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_err;
  logic [W-1:0]  r;

  int n_chk  = 0;
  int n_fail = 0;

  barrett_correction #(.width(W), .rw(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_lo      (x_lo),
    .qm_lo     (qm_lo),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void reduce(input logic [RW-1:0] x, input logic [RW-1:0] qm,
                                 input logic [W-1:0] mm,
                                 output logic [W-1:0] rr, output logic ee);
    logic [RW-1:0] t;
    logic [RW-1:0] me;
    me = {2'b00, mm};
    t  = x - qm;
    for (int k = 0; k < 2; k++) begin
      if (t >= me) t = t - me;
    end
    rr = t[W-1:0];
    ee = (t >= me);
  endfunction

  bit           mdl_busy  = 1'b0;
  int           mdl_cnt   = 0;      // edges since the accept
  logic [W-1:0] pend_r    = '0;
  logic         pend_e    = 1'b0;
  logic [W-1:0] vis_r     = '0;
  logic         vis_e     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy = 1'b0;
      mdl_cnt  = 0;
      vis_r    = '0;
      vis_e    = 1'b0;
    end else if (!mdl_busy) begin
      if (in_valid) begin
        mdl_busy = 1'b1;
        mdl_cnt  = 0;
        reduce(x_lo, qm_lo, m, pend_r, pend_e);
      end
    end else if (mdl_cnt >= 3) begin
      if (out_ready) mdl_busy = 1'b0;
    end else begin
      mdl_cnt++;
      if (mdl_cnt == 3) begin
        vis_r = pend_r;
        vis_e = pend_e;
      end
    end
  end

  always @(negedge clk) begin
    checkb("in_ready", in_ready, !mdl_busy);
    checkb("out_valid", out_valid, mdl_busy && (mdl_cnt >= 3));
    check("r", r, vis_r);
    checkb("out_err", out_err, vis_e);
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input logic [RW-1:0] x, input logic [RW-1:0] qm, input logic [W-1:0] mm,
                        input logic [W-1:0] exp_r, input logic exp_e, input int hold);
    int lat;
    @(posedge clk); #1;
    x_lo = x; qm_lo = qm; m = mm; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // Garbage after the accept edge must not disturb the result.
    in_valid = 1'b0; x_lo = '1; qm_lo = '0; m = '1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", W'(lat), W'(3));
    check("lit_r", r, exp_r);
    checkb("lit_err", out_err, exp_e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkb("hold_valid", out_valid, 1'b1);
      checkb("hold_in_ready", in_ready, 1'b0);
      check("hold_r", r, exp_r);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkb("release_valid", out_valid, 1'b0);
    checkb("release_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0]  mmax;
    logic [RW-1:0] two_m;
    int            nvalid;

    mmax  = '1;
    two_m = {1'b0, mmax, 1'b0};

    #12;
    checkb("rst_in_ready", in_ready, 1'b1);
    checkb("rst_out_valid", out_valid, 1'b0);
    check("rst_r", r, '0);
    checkb("rst_err", out_err, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // basic: 20 -> 13 -> 6
    run_op(112'd27, 112'd7, 110'd7, 110'd6, 1'b0, 0);
    // no correction needed
    run_op(112'd1500, 112'd1000, 110'd1000, 110'd500, 1'b0, 0);
    // wrap: t = 2^112-2, two subtractions of 7 leave 2^112-16
    run_op(112'd3, 112'd5, 110'd7, ~110'hF, 1'b1, 0);
    // backpressure for 10 cycles
    run_op(112'd1500, 112'd1000, 110'd1000, 110'd500, 1'b0, 10);
    // boundary: x - qm = 2m with the largest modulus
    run_op(two_m, 112'd0, mmax, 110'd0, 1'b0, 0);
    // same difference with m = 0: nothing subtracted, 2^111-2 truncated
    run_op(two_m, 112'd0, 110'd0, ~110'h1, 1'b1, 0);

    // back-to-back accepts with in_valid and out_ready held high
    @(posedge clk); #1;
    x_lo = 112'd27; qm_lo = 112'd7; m = 110'd7; in_valid = 1'b1; out_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        nvalid++;
        check("b2b_r", r, 110'd6);
      end
    end
    check("b2b_count", W'(nvalid), W'(3));
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 out_ready = 1'b0;

    // reset during COR1
    @(posedge clk); #1;
    x_lo = 112'd3; qm_lo = 112'd5; m = 110'd7; in_valid = 1'b1;
    @(posedge clk); #1;          // accepted
    in_valid = 1'b0;
    @(posedge clk); #2;          // now in COR1
    rst_n = 1'b0;
    #1;
    checkb("midrst_out_valid", out_valid, 1'b0);
    checkb("midrst_in_ready", in_ready, 1'b1);
    check("midrst_r", r, '0);
    checkb("midrst_err", out_err, 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;
    run_op(112'd27, 112'd7, 110'd7, 110'd6, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
